// File: rtl/fp_int_to_float.sv
// Integer-to-single-precision converter (FCVT.S.W / FCVT.S.WU), three-cycle FSM pipeline.
// Define FP_CVT_UNSIGNED_EN to decode FCVT.S.WU; otherwise only FCVT.S.W is supported.

package riscv_pkg;

    typedef enum logic [3:0] {
        OP_NONE   = 4'd0,
        FCVT_W_S  = 4'd1,
        FCVT_WU_S = 4'd2,
        FCVT_S_W  = 4'd3,
        FCVT_S_WU = 4'd4,
        FMIN_S    = 4'd5,
        FMAX_S    = 4'd6,
        FEQ_S     = 4'd7,
        FLT_S     = 4'd8,
        FLE_S     = 4'd9
    } instr_op_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

endpackage

module fp_int_to_float
    import riscv_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_operand,
    input  instr_op_e   i_operation,
    input  logic [2:0]  i_rounding_mode,
    output logic [31:0] o_result,
    output logic        o_valid,
    output logic        o_busy,
    output fp_flags_t   o_flags
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STAGE1 = 2'd1,
        STAGE2 = 2'd2
    } state_e;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    state_e      state_q;

    // Captured request
    logic [31:0] operand_q;
    instr_op_e   op1_q;
    logic [2:0]  rm1_q;

    // STAGE1 -> STAGE2 pipeline registers
    logic        sign_q;
    logic [31:0] mag_q;
    logic [4:0]  lzc_q;
    logic        zero_q;
    instr_op_e   op2_q;
    logic [2:0]  rm2_q;

    // Registered outputs
    logic [31:0] result_q;
    fp_flags_t   flags_q;
    logic        valid_q;

    // STAGE1 combinational
    logic        sign_d;
    logic [31:0] mag_d;
    logic [4:0]  lzc_d;
    logic        zero_d;

    always_comb begin
        sign_d = (op1_q == FCVT_S_W) && operand_q[31];
        mag_d  = sign_d ? (~operand_q + 32'd1) : operand_q;
        zero_d = (mag_d == 32'd0);
        lzc_d  = 5'd0;
        // Ascending scan: the highest set bit is the last to write lzc_d.
        for (int i = 0; i < 32; i++) begin
            if (mag_d[i]) begin
                lzc_d = 5'(31 - i);
            end
        end
    end

    // STAGE2 combinational
    logic [30:0] norm_d;
    logic [7:0]  exp_d;
    logic [22:0] mant_d;
    logic        guard_d;
    logic        sticky_d;
    logic        inc_d;
    logic [23:0] mant_sum_d;
    logic [7:0]  exp_rnd_d;
    logic        op_known_d;
    logic [31:0] result_d;
    fp_flags_t   flags_d;

    always_comb begin
        // Bit 31 of the shifted magnitude is the implicit leading one, so it is dropped.
        norm_d   = 31'(mag_q << lzc_q);
        exp_d    = 8'd158 - {3'b000, lzc_q};
        mant_d   = norm_d[30:8];
        guard_d  = norm_d[7];
        sticky_d = |norm_d[6:0];

        case (rm2_q)
            RM_RNE:  inc_d = guard_d & (sticky_d | mant_d[0]);
            RM_RTZ:  inc_d = 1'b0;
            RM_RDN:  inc_d = sign_q & (guard_d | sticky_d);
            RM_RUP:  inc_d = ~sign_q & (guard_d | sticky_d);
            RM_RMM:  inc_d = guard_d;
            default: inc_d = guard_d & (sticky_d | mant_d[0]);
        endcase

        // A mantissa carry-out wraps the fraction to zero and bumps the exponent (max 159).
        mant_sum_d = {1'b0, mant_d} + {23'd0, inc_d};
        exp_rnd_d  = exp_d + {7'd0, mant_sum_d[23]};

`ifdef FP_CVT_UNSIGNED_EN
        op_known_d = (op2_q == FCVT_S_W) || (op2_q == FCVT_S_WU);
`else
        op_known_d = (op2_q == FCVT_S_W);
`endif

        result_d = 32'd0;
        flags_d  = '0;
        if (op_known_d && !zero_q) begin
            result_d   = {sign_q, exp_rnd_d, mant_sum_d[22:0]};
            flags_d.nx = guard_d | sticky_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            operand_q <= 32'd0;
            op1_q     <= OP_NONE;
            rm1_q     <= 3'd0;
            sign_q    <= 1'b0;
            mag_q     <= 32'd0;
            lzc_q     <= 5'd0;
            zero_q    <= 1'b0;
            op2_q     <= OP_NONE;
            rm2_q     <= 3'd0;
            result_q  <= 32'd0;
            flags_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        operand_q <= i_operand;
                        op1_q     <= i_operation;
                        rm1_q     <= i_rounding_mode;
                        state_q   <= STAGE1;
                    end
                end
                STAGE1: begin
                    sign_q  <= sign_d;
                    mag_q   <= mag_d;
                    lzc_q   <= lzc_d;
                    zero_q  <= zero_d;
                    op2_q   <= op1_q;
                    rm2_q   <= rm1_q;
                    state_q <= STAGE2;
                end
                STAGE2: begin
                    result_q <= result_d;
                    flags_q  <= flags_d;
                    valid_q  <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_result = result_q;
    assign o_flags  = flags_q;
    assign o_valid  = valid_q;
    assign o_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_fp_int_to_float.sv
// Directed self-checking bench for fp_int_to_float: rounding modes, latency, busy-ignore and reset abort.
module tb_fp_int_to_float;
    import riscv_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_operand;
    instr_op_e   i_operation;
    logic [2:0]  i_rounding_mode;
    logic [31:0] o_result;
    logic        o_valid;
    logic        o_busy;
    fp_flags_t   o_flags;

    int n_checks;
    int n_fail;

    fp_int_to_float dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_valid         (i_valid),
        .i_operand       (i_operand),
        .i_operation     (i_operation),
        .i_rounding_mode (i_rounding_mode),
        .o_result        (o_result),
        .o_valid         (o_valid),
        .o_busy          (o_busy),
        .o_flags         (o_flags)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Called at a negedge with the block idle; returns at the negedge where o_valid is seen.
    task automatic do_op(input string tag, input instr_op_e op, input logic [31:0] a,
                         input logic [2:0] rm, input logic [31:0] exp_res, input logic [4:0] exp_flags);
        int lat;
        i_valid         = 1'b1;
        i_operand       = a;
        i_operation     = op;
        i_rounding_mode = rm;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            @(posedge i_clk);
            @(negedge i_clk);
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'd3);
        check({tag, ".res"}, o_result, exp_res);
        check({tag, ".flg"}, {27'd0, o_flags}, {27'd0, exp_flags});
    endtask

    initial begin
        int pulses;
        n_checks        = 0;
        n_fail          = 0;
        i_rst           = 1'b1;
        i_valid         = 1'b0;
        i_operand       = 32'd0;
        i_operation     = OP_NONE;
        i_rounding_mode = 3'd0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        check("rst.valid", {31'd0, o_valid}, 32'd0);
        check("rst.busy",  {31'd0, o_busy},  32'd0);
        check("rst.res",   o_result, 32'd0);
        check("rst.flg",   {27'd0, o_flags}, 32'd0);

        // Consecutive calls issue on the o_valid cycle, i.e. back-to-back every 3 cycles.
        do_op("w_m1",    FCVT_S_W, 32'hFFFF_FFFF, 3'b000, 32'hBF80_0000, 5'b00000);
        do_op("w_zero",  FCVT_S_W, 32'h0000_0000, 3'b000, 32'h0000_0000, 5'b00000);
        do_op("w_min",   FCVT_S_W, 32'h8000_0000, 3'b000, 32'hCF00_0000, 5'b00000);
`ifdef FP_CVT_UNSIGNED_EN
        do_op("wu_max",  FCVT_S_WU, 32'hFFFF_FFFF, 3'b000, 32'h4F80_0000, 5'b00001);
`else
        do_op("wu_off",  FCVT_S_WU, 32'hFFFF_FFFF, 3'b000, 32'h0000_0000, 5'b00000);
`endif
        do_op("rne",     FCVT_S_W, 32'h0100_0001, 3'b000, 32'h4B80_0000, 5'b00001);
        do_op("rup",     FCVT_S_W, 32'h0100_0001, 3'b011, 32'h4B80_0001, 5'b00001);
        do_op("rtz",     FCVT_S_W, 32'h0100_0001, 3'b001, 32'h4B80_0000, 5'b00001);
        do_op("rmm",     FCVT_S_W, 32'h0100_0001, 3'b100, 32'h4B80_0001, 5'b00001);
        do_op("neg_rdn", FCVT_S_W, 32'hFEFF_FFFF, 3'b010, 32'hCB80_0001, 5'b00001);
        do_op("neg_rup", FCVT_S_W, 32'hFEFF_FFFF, 3'b011, 32'hCB80_0000, 5'b00001);
        do_op("w_three", FCVT_S_W, 32'h0000_0003, 3'b000, 32'h4040_0000, 5'b00000);
        do_op("unk_op",  FMIN_S,   32'h0000_0005, 3'b000, 32'h0000_0000, 5'b00000);
        do_op("w_one",   FCVT_S_W, 32'h0000_0001, 3'b000, 32'h3F80_0000, 5'b00000);

        // Hold i_valid through STAGE1/STAGE2 with a different operand: must be ignored.
        @(negedge i_clk);
        i_valid         = 1'b1;
        i_operand       = 32'h0000_0002;
        i_operation     = FCVT_S_W;
        i_rounding_mode = 3'b000;
        @(posedge i_clk);
        @(negedge i_clk);
        check("busy.s1", {31'd0, o_busy}, 32'd1);
        i_operand = 32'h0000_0007;
        @(posedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        pulses  = o_valid ? 1 : 0;
        check("busy.res", o_result, 32'h4000_0000);
        repeat (6) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_valid) pulses++;
        end
        check("busy.pulses", 32'(pulses), 32'd1);

        // Reset during STAGE1 drops the conversion.
        i_valid   = 1'b1;
        i_operand = 32'h0000_0009;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst  = 1'b0;
        check("abort.busy", {31'd0, o_busy}, 32'd0);
        check("abort.res",  o_result, 32'd0);
        check("abort.flg",  {27'd0, o_flags}, 32'd0);
        pulses = 0;
        repeat (6) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_valid) pulses++;
        end
        check("abort.pulses", 32'(pulses), 32'd0);

        do_op("post_rst", FCVT_S_W, 32'hFFFF_FFFE, 3'b000, 32'hC000_0000, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_int_to_float.md
# fp_int_to_float

Converts a 32-bit integer from the integer register file into an IEEE 754 single-precision value, implementing FCVT.S.W (signed) and FCVT.S.WU (unsigned). It sits in the EX-stage FPU next to the comparison/min-max unit. That unit moves FP values out to integer registers; this block moves integer values into FP registers. It is a 3-cycle state-machine pipeline that accepts one operation at a time and produces a rounded result plus accrued exception flags.

## Interface
- No parameters.
- i_clk  input  1  clock
- i_rst  input  1  synchronous, active-high reset
- i_valid  input  1  start request; sampled only in IDLE
- i_operand  input  32  integer source (rs1)
- i_operation  input  riscv_pkg::instr_op_e  FCVT_S_W or FCVT_S_WU
- i_rounding_mode  input  3  resolved rounding mode (DYN already replaced upstream)
- o_result  output  32  single-precision result, to FP register
- o_valid  output  1  one-cycle pulse; result and flags valid
- o_busy  output  1  high whenever state != IDLE
- o_flags  output  riscv_pkg::fp_flags_t  exception flags; only nx is ever set

## Operation
- FSM states: IDLE, STAGE1, STAGE2.
  - IDLE -> STAGE1 on i_valid; STAGE1 -> STAGE2 unconditionally; STAGE2 -> IDLE unconditionally; any other encoding -> IDLE.
- IDLE capture: on i_valid, register i_operand, i_operation and i_rounding_mode.
- STAGE1:
  - sign = operand[31] for FCVT_S_W; sign = 0 for FCVT_S_WU.
  - Magnitude = two's-complement negation when sign = 1, else the operand; 32-bit unsigned, so 0x80000000 is valid.
  - Zero detect.
  - 5-bit leading-zero count of the magnitude.
  - Register sign, magnitude, lzc, zero, operation and rounding mode.
- STAGE2 normalize:
  - norm = magnitude << lzc, so the leading one is at bit 31.
  - Biased exponent = 158 - lzc.
  - Mantissa = norm[30:8], guard = norm[7], sticky = |norm[6:0].
- STAGE2 rounding increment:
  - RNE (000): guard & (sticky | mant[0]).
  - RTZ (001): 0.
  - RDN (010): sign & (guard|sticky).
  - RUP (011): ~sign & (guard|sticky).
  - RMM (100): guard.
  - 101/110/111: treated as RNE, no flag (the decoder traps these earlier).
- Mantissa carry-out: mantissa becomes 0 and exponent increments. Maximum exponent is 159, so overflow is impossible.
- Zero input: result 0x00000000 (+0, never -0), flags 0.
- Flags: nx = guard|sticky. nv, of, uf and dz are always 0.
- Unknown operation: result 0, flags 0, o_valid still pulses.

## Timing
- i_valid accepted in cycle T (IDLE). STAGE1 at T+1, STAGE2 at T+2, o_valid high in T+3 only.
- o_result and o_flags are registered and hold their value until the next completion.
- i_valid is ignored while o_busy = 1. There is no queuing; the issuer must wait for IDLE.
- i_valid may be asserted in the same cycle as o_valid, since state is IDLE then. The new operation completes 3 cycles later.
- Reset values: state IDLE, o_valid 0, o_busy 0, o_result 0, o_flags 0. All pipeline registers are 0.
- Reset mid-operation: the in-flight conversion is dropped, no o_valid pulse occurs, and the block is in IDLE the cycle after reset deasserts.

## Configuration
- FP_CVT_UNSIGNED_EN defined:
  - FCVT_S_WU is supported as described above.
- FP_CVT_UNSIGNED_EN undefined:
  - The unsigned path is compiled out and only FCVT_S_W is decoded.
  - FCVT_S_WU falls into the unknown-operation case: result 0, flags 0, o_valid pulses at T+3.

## Test plan
- FCVT_S_W, 0x00000000, RNE -> 0x00000000, nx 0. FCVT_S_W, 0xFFFFFFFF (-1) -> 0xBF800000, nx 0. Both with o_valid exactly 3 cycles after i_valid.
- FCVT_S_W, 0x80000000 -> 0xCF000000, nx 0. FCVT_S_WU, 0xFFFFFFFF, RNE -> 0x4F800000, nx 1 (mantissa carry into exponent). The WU case runs only with the macro defined.
- 0x01000001 (FCVT_S_W):
  - RNE -> 0x4B800000, nx 1.
  - RUP -> 0x4B800001.
  - RTZ -> 0x4B800000.
  - RMM -> 0x4B800001.
- 0xFEFFFFFF (-16777217), FCVT_S_W:
  - RDN -> 0xCB800001.
  - RUP -> 0xCB800000.
  - Both nx 1.
- Issue a second i_valid during STAGE1 and STAGE2 -> ignored, exactly one o_valid. Issue back-to-back at each o_valid cycle -> one result every 3 cycles.
- Assert i_rst during STAGE1 -> no o_valid pulse. Outputs read 0 and o_busy 0 after reset.
